// File: rtl/conv_channel_sequencer.sv
// Depthwise conv layer controller: loads per-channel weights/biases from the
// parameter memory, flushes the shared engine and streams one channel at a time.
module conv_channel_sequencer #(
  parameter int PIX_WIDTH  = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int CH_WIDTH   = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CH_WIDTH-1:0]       num_channels,
  input  logic [7:0]                input_dim,
  input  logic                      stride,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err,
  output logic                      pmem_rd,
  output logic [ADDR_WIDTH-1:0]     pmem_addr,
  input  logic [PIX_WIDTH-1:0]      pmem_data,
  input  logic                      pix_valid,
  input  logic [PIX_WIDTH-1:0]      pix_data,
  output logic                      pix_ready,
  output logic [8:0][PIX_WIDTH-1:0] conv_weights,
  output logic [8:0][PIX_WIDTH-1:0] conv_biases,
  output logic                      conv_flush,
  output logic [PIX_WIDTH-1:0]      conv_pixel,
  output logic                      conv_pixel_valid,
  input  logic                      conv_idle,
  output logic                      conv_accept,
  input  logic [31:0]               conv_result,
  input  logic                      conv_result_valid,
  output logic [31:0]               out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_STREAM,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [CH_WIDTH-1:0]   CH_ONE    = CH_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CH_STRIDE = ADDR_WIDTH'(18);
  localparam logic [4:0]            LOAD_END  = 5'd18;

  state_t                state, state_next;
  logic [CH_WIDTH-1:0]   nch_q;
  logic [CH_WIDTH-1:0]   ch_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [4:0]            k_q;
  logic [15:0]           pix_total_q;
  logic [15:0]           res_total_q;
  logic [15:0]           pix_cnt;
  logic [15:0]           res_cnt;
  logic                  done_q;
  logic                  cfg_err_q;

  logic                  done_set;
  logic                  cfg_set;
  logic                  res_take;
  logic [15:0]           pix_cnt_nxt;
  logic [15:0]           res_cnt_nxt;
  logic [7:0]            n_out;
  logic [15:0]           e_calc;
  logic [15:0]           p_calc;

  assign n_out  = ((input_dim - 8'd3) >> stride) + 8'd1;
  assign e_calc = 16'(n_out) * 16'(n_out);
  assign p_calc = 16'(input_dim) * 16'(input_dim);

  assign busy             = (state != S_IDLE) && (state != S_DONE);
  assign done             = (state == S_DONE) || done_q;
  assign cfg_err          = cfg_err_q;
  assign pmem_rd          = (state == S_LOAD) && (k_q < LOAD_END);
  assign pmem_addr        = pmem_rd ? (base_q + ADDR_WIDTH'(k_q)) : '0;
  assign conv_flush       = (state == S_FLUSH);
  assign pix_ready        = (state == S_STREAM) && conv_idle && (pix_cnt < pix_total_q);
  assign conv_pixel       = pix_data;
  assign conv_pixel_valid = pix_valid && pix_ready;
  assign conv_accept      = out_ready;
  // Results past the expected count are swallowed, not forwarded nor counted.
  assign res_take         = (state == S_STREAM) && conv_result_valid && (res_cnt < res_total_q);
  assign out_valid        = res_take;
  assign out_data         = conv_result;
  assign pix_cnt_nxt      = pix_cnt + 16'(conv_pixel_valid);
  assign res_cnt_nxt      = res_cnt + 16'(res_take);

  always_comb begin
    state_next = state;
    done_set   = 1'b0;
    cfg_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (input_dim < 8'd3) begin
            done_set = 1'b1;
            cfg_set  = 1'b1;
          end else if (num_channels == '0) begin
            done_set = 1'b1;
          end else begin
            state_next = S_LOAD;
          end
        end
      end
      S_LOAD:   if (k_q == LOAD_END) state_next = S_FLUSH;
      S_FLUSH:  state_next = S_STREAM;
      S_STREAM: begin
        if ((pix_cnt_nxt == pix_total_q) && (res_cnt_nxt == res_total_q))
          state_next = S_NEXT;
      end
      S_NEXT:   state_next = ((ch_q + CH_ONE) == nch_q) ? S_DONE : S_LOAD;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      nch_q        <= '0;
      ch_q         <= '0;
      base_q       <= '0;
      k_q          <= '0;
      pix_total_q  <= '0;
      res_total_q  <= '0;
      pix_cnt      <= '0;
      res_cnt      <= '0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      conv_weights <= '0;
      conv_biases  <= '0;
    end else begin
      state     <= state_next;
      done_q    <= done_set;
      cfg_err_q <= cfg_set;
      case (state)
        S_IDLE: begin
          if (state_next == S_LOAD) begin
            nch_q       <= num_channels;
            pix_total_q <= p_calc;
            res_total_q <= e_calc;
            ch_q        <= '0;
            base_q      <= '0;
            k_q         <= '0;
          end
        end
        S_LOAD: begin
          k_q <= k_q + 5'd1;
          // Byte k arrives one cycle after its read, i.e. while k_q == k+1.
          for (int unsigned i = 0; i < 9; i++) begin
            if (k_q == 5'(i + 1))  conv_weights[i] <= pmem_data;
            if (k_q == 5'(i + 10)) conv_biases[i]  <= pmem_data;
          end
        end
        S_FLUSH: begin
          pix_cnt <= '0;
          res_cnt <= '0;
        end
        S_STREAM: begin
          pix_cnt <= pix_cnt_nxt;
          res_cnt <= res_cnt_nxt;
        end
        S_NEXT: begin
          ch_q   <= ch_q + CH_ONE;
          base_q <= base_q + CH_STRIDE;
          k_q    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_channel_sequencer.sv
// Directed bench for conv_channel_sequencer with a behavioural parameter ROM,
// pixel ramp source and a simple 3x3 window engine model.
module tb_conv_channel_sequencer;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       num_channels = '0;
  logic [7:0]       input_dim = '0;
  logic             stride = 1'b0;
  logic             busy, done, cfg_err, pmem_rd;
  logic [11:0]      pmem_addr;
  logic [7:0]       pmem_data = '0;
  logic             pix_valid;
  logic [7:0]       pix_data;
  logic             pix_ready;
  logic [8:0][7:0]  conv_weights, conv_biases;
  logic             conv_flush;
  logic [7:0]       conv_pixel;
  logic             conv_pixel_valid;
  logic             conv_idle;
  logic             conv_accept;
  logic [31:0]      conv_result;
  logic             conv_result_valid;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  conv_channel_sequencer #(.PIX_WIDTH(8), .ADDR_WIDTH(12), .CH_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .num_channels(num_channels),
    .input_dim(input_dim), .stride(stride), .busy(busy), .done(done),
    .cfg_err(cfg_err), .pmem_rd(pmem_rd), .pmem_addr(pmem_addr),
    .pmem_data(pmem_data), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .conv_weights(conv_weights), .conv_biases(conv_biases),
    .conv_flush(conv_flush), .conv_pixel(conv_pixel),
    .conv_pixel_valid(conv_pixel_valid), .conv_idle(conv_idle),
    .conv_accept(conv_accept), .conv_result(conv_result),
    .conv_result_valid(conv_result_valid), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  // Parameter ROM: word a holds a+1, one-cycle read latency.
  always @(posedge clock) if (pmem_rd) pmem_data <= 8'(pmem_addr + 12'd1);

  // Pixel ramp 1,2,3,... restarting at each flush.
  logic [7:0] src_idx = '0;
  assign pix_valid = 1'b1;
  assign pix_data  = src_idx + 8'd1;
  always @(posedge clock) begin
    if (conv_flush) src_idx <= '0;
    else if (conv_pixel_valid) src_idx <= src_idx + 8'd1;
  end

  // Engine model: emits the pixel value at each valid window centre, holds it
  // (and goes busy) until conv_accept takes it.
  int cfg_d = 5;
  int cfg_step = 1;
  int eng_row, eng_col;
  logic eng_pend;
  logic [31:0] eng_val;
  assign conv_idle         = !eng_pend;
  assign conv_result_valid = eng_pend && conv_accept;
  assign conv_result       = eng_val;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      eng_pend <= 1'b0; eng_val <= '0; eng_row <= 0; eng_col <= 0;
    end else if (conv_flush) begin
      eng_pend <= 1'b0; eng_row <= 0; eng_col <= 0;
    end else begin
      if (eng_pend && conv_accept) eng_pend <= 1'b0;
      if (conv_pixel_valid) begin
        if (eng_row >= 2 && eng_col >= 2 && ((eng_row - 2) % cfg_step) == 0 &&
            ((eng_col - 2) % cfg_step) == 0) begin
          eng_pend <= 1'b1;
          eng_val  <= {24'h0, conv_pixel};
        end
        if (eng_col == cfg_d - 1) begin
          eng_col <= 0; eng_row <= eng_row + 1;
        end else begin
          eng_col <= eng_col + 1;
        end
      end
    end
  end

  // Monitors
  int rd_count, flush_count, outv_count, done_count, cfg_count, bad_valid;
  longint out_sum;
  logic rd_prev = 1'b0;
  logic [11:0] addr_log[$];
  logic [11:0] base_log[$];
  always @(negedge clock) begin
    if (pmem_rd) begin
      rd_count++;
      addr_log.push_back(pmem_addr);
      if (!rd_prev) base_log.push_back(pmem_addr);
    end
    rd_prev = pmem_rd;
    if (conv_flush) flush_count++;
    if (out_valid) begin
      outv_count++;
      out_sum += longint'(out_data);
      if (!out_ready) bad_valid++;
    end
    if (done) done_count++;
    if (cfg_err) cfg_count++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_counts();
    rd_count = 0; flush_count = 0; outv_count = 0; done_count = 0;
    cfg_count = 0; bad_valid = 0; out_sum = 0;
    addr_log.delete(); base_log.delete();
  endtask

  task automatic pulse_start(input logic [7:0] nc, input logic [7:0] d, input logic s);
    num_channels = nc; input_dim = d; stride = s;
    cfg_d = int'(d); cfg_step = s ? 2 : 1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    int d0 = done_count;
    while (done_count == d0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done_count == d0) begin
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, done, cfg_err, pmem_rd, conv_flush, pix_ready, out_valid} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {busy, done, cfg_err, pmem_rd, conv_flush, pix_ready, out_valid});
    end
    checks++;
    if (pmem_addr !== 12'h0 || conv_weights !== '0 || conv_biases !== '0) begin
      failures++;
      $display("FAIL reset_regs: addr=%h w=%h b=%h want zeros", pmem_addr, conv_weights, conv_biases);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_channel();
    logic [8:0][7:0] exp_w, exp_b;
    int addr_err = 0;
    clear_counts();
    pulse_start(8'd1, 8'd5, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy: got %b want 1", busy);
    end
    wait_done(1000, "single");
    tick();
    checks++;
    if (rd_count != 18) begin
      failures++;
      $display("FAIL single_reads: got %0d want 18", rd_count);
    end
    foreach (addr_log[i]) if (addr_log[i] !== 12'(i)) addr_err++;
    checks++;
    if (addr_err != 0) begin
      failures++;
      $display("FAIL single_addr_seq: got %0d wrong addresses want 0", addr_err);
    end
    for (int i = 0; i < 9; i++) begin
      exp_w[i] = 8'(i + 1);
      exp_b[i] = 8'(i + 10);
    end
    checks++;
    if (conv_weights !== exp_w || conv_biases !== exp_b) begin
      failures++;
      $display("FAIL single_params: w=%h b=%h want w=%h b=%h", conv_weights, conv_biases, exp_w, exp_b);
    end
    checks++;
    if (flush_count != 1 || outv_count != 9) begin
      failures++;
      $display("FAIL single_stream: flushes=%0d results=%0d want 1 and 9", flush_count, outv_count);
    end
    checks++;
    if (out_sum != 171) begin
      failures++;
      $display("FAIL single_result_sum: got %0d want 171", out_sum);
    end
    checks++;
    if (busy !== 1'b0 || done_count != 1 || cfg_count != 0) begin
      failures++;
      $display("FAIL single_end: busy=%b dones=%0d cfg_errs=%0d want 0 1 0", busy, done_count, cfg_count);
    end
  endtask

  task automatic test_multi_channel();
    logic [8:0][7:0] exp_w, exp_b;
    clear_counts();
    pulse_start(8'd3, 8'd7, 1'b1);
    wait_done(3000, "multi");
    tick();
    checks++;
    if (base_log.size() != 3 || base_log[0] !== 12'd0 || base_log[1] !== 12'd18 || base_log[2] !== 12'd36) begin
      failures++;
      $display("FAIL multi_bases: got %0d bursts first=%0d want 3 bursts at 0,18,36",
               base_log.size(), (base_log.size() > 0) ? base_log[0] : 12'hfff);
    end
    checks++;
    if (rd_count != 54 || flush_count != 3 || outv_count != 27 || done_count != 1) begin
      failures++;
      $display("FAIL multi_counts: reads=%0d flushes=%0d results=%0d dones=%0d want 54 3 27 1",
               rd_count, flush_count, outv_count, done_count);
    end
    for (int i = 0; i < 9; i++) begin
      exp_w[i] = 8'(37 + i);
      exp_b[i] = 8'(46 + i);
    end
    checks++;
    if (conv_weights !== exp_w || conv_biases !== exp_b) begin
      failures++;
      $display("FAIL multi_last_params: w=%h b=%h want w=%h b=%h", conv_weights, conv_biases, exp_w, exp_b);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    clear_counts();
    pulse_start(8'd1, 8'd5, 1'b0);
    while (outv_count < 3 && n < 500) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    repeat (20) tick();
    checks++;
    if (pix_ready !== 1'b0 || outv_count != 3) begin
      failures++;
      $display("FAIL bp_stall: pix_ready=%b results=%0d want 0 and 3", pix_ready, outv_count);
    end
    out_ready = 1'b1;
    wait_done(1000, "bp");
    checks++;
    if (outv_count != 9 || out_sum != 171 || bad_valid != 0) begin
      failures++;
      $display("FAIL bp_results: results=%0d sum=%0d valid_while_low=%0d want 9 171 0",
               outv_count, out_sum, bad_valid);
    end
  endtask

  task automatic test_cfg_err();
    clear_counts();
    pulse_start(8'd1, 8'd2, 1'b0);
    checks++;
    if (done !== 1'b1 || cfg_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cfgerr_pulse: done=%b cfg_err=%b busy=%b want 1 1 0", done, cfg_err, busy);
    end
    repeat (5) tick();
    checks++;
    if (done !== 1'b0 || cfg_err !== 1'b0 || rd_count != 0 || done_count != 1) begin
      failures++;
      $display("FAIL cfgerr_after: done=%b cfg_err=%b reads=%0d dones=%0d want 0 0 0 1",
               done, cfg_err, rd_count, done_count);
    end
  endtask

  task automatic test_zero_channels();
    clear_counts();
    pulse_start(8'd0, 8'd5, 1'b0);
    checks++;
    if (done !== 1'b1 || cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL zero_ch_pulse: done=%b cfg_err=%b want 1 0", done, cfg_err);
    end
    repeat (5) tick();
    checks++;
    if (rd_count != 0 || done_count != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_ch_after: reads=%0d dones=%0d busy=%b want 0 1 0", rd_count, done_count, busy);
    end
  endtask

  task automatic test_start_while_busy();
    clear_counts();
    pulse_start(8'd1, 8'd5, 1'b0);
    repeat (3) tick();
    num_channels = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1000, "busy_start");
    repeat (10) tick();
    checks++;
    if (done_count != 1 || flush_count != 1 || rd_count != 18) begin
      failures++;
      $display("FAIL busy_start_ignored: dones=%0d flushes=%0d reads=%0d want 1 1 18",
               done_count, flush_count, rd_count);
    end
  endtask

  task automatic test_reset_mid_layer();
    int n = 0;
    clear_counts();
    pulse_start(8'd2, 8'd5, 1'b0);
    while (flush_count < 2 && n < 1000) begin
      tick();
      n++;
    end
    repeat (5) tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, cfg_err, pmem_rd, conv_flush, pix_ready, out_valid} !== 7'b0 || pmem_addr !== 12'h0) begin
      failures++;
      $display("FAIL midreset_outputs: ctrl=%b addr=%h want 0000000 and 000",
               {busy, done, cfg_err, pmem_rd, conv_flush, pix_ready, out_valid}, pmem_addr);
    end
    tick();
    reset = 1'b0;
    clear_counts();
    repeat (5) tick();
    checks++;
    if (done_count != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_done: dones=%0d busy=%b want 0 0", done_count, busy);
    end
    pulse_start(8'd1, 8'd5, 1'b0);
    wait_done(1000, "midreset_restart");
    checks++;
    if (base_log.size() != 1 || base_log[0] !== 12'd0 || rd_count != 18) begin
      failures++;
      $display("FAIL midreset_restart: bursts=%0d reads=%0d want 1 burst from 0 with 18 reads",
               base_log.size(), rd_count);
    end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_single_channel();
    test_multi_channel();
    test_backpressure();
    test_cfg_err();
    test_zero_channels();
    test_start_while_busy();
    test_reset_mid_layer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/conv_channel_sequencer.md
Name: conv_channel_sequencer

Overview:
- Controller that runs one depthwise conv layer through a single shared conv engine, one channel at a time.
- Per channel, it loads 9 weights and 9 biases from the parameter memory, flushes the engine's line window, streams input_dim×input_dim pixels in, and forwards the engine's results downstream.
- Sits between the feature-map buffer / parameter ROM and the conv engine instance.

Parameters:
- PIX_WIDTH, 8, pixel and parameter byte width.
- ADDR_WIDTH, 12, parameter memory address width.
- CH_WIDTH, 8, channel count width.

Ports:
- clock  in  1  system clock.
- reset  in  1  async active-high reset.
- start  in  1  one-cycle layer start; ignored while busy=1.
- num_channels  in  CH_WIDTH  channels in the layer; sampled on start.
- input_dim  in  8  feature-map side D; sampled on start.
- stride  in  1  0 = stride 1, 1 = stride 2; sampled on start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at layer end.
- cfg_err  out  1  one-cycle pulse with done when D<3.
- pmem_rd  out  1  parameter read strobe.
- pmem_addr  out  ADDR_WIDTH  parameter read address.
- pmem_data  in  PIX_WIDTH  read data, valid the cycle after pmem_rd.
- pix_valid  in  1  source pixel valid.
- pix_data  in  PIX_WIDTH  source pixel.
- pix_ready  out  1  sequencer accepts pixel this cycle.
- conv_weights  out  9×8  registered weights, index 0..8.
- conv_biases  out  9×8  registered biases, index 0..8.
- conv_flush  out  1  one-cycle pulse, OR-ed into engine reset by the parent.
- conv_pixel  out  PIX_WIDTH  equals pix_data.
- conv_pixel_valid  out  1  pix_valid & pix_ready.
- conv_idle  in  1  engine idle (ready for pixel).
- conv_accept  out  1  equals out_ready.
- conv_result  in  32  engine result.
- conv_result_valid  in  1  engine result pulse.
- out_data  out  32  equals conv_result.
- out_valid  out  1  equals conv_result_valid while in STREAM.
- out_ready  in  1  downstream accepting.

Behaviour:
- Reset: state IDLE; busy, done, cfg_err, pmem_rd, conv_flush, pix_ready = 0; pmem_addr, weights, biases, all counters = 0. Reset mid-layer aborts immediately; no done is issued.
- Parameter layout: channel c occupies a base of c×18. Words 0..8 hold weights[0..8]; words 9..17 hold biases[0..8].
- Output count per channel: N = ((D-3)>>stride)+1. E = N×N (16 bit), computed and latched on start. P = D×D (16 bit) is also latched.
- IDLE:
  - start with D<3 → done and cfg_err pulse next cycle; stay IDLE.
  - start with num_channels=0 → done pulse next cycle, no cfg_err.
  - Otherwise: ch=0, base=0, busy=1, go to LOAD.
- LOAD: issue pmem_rd for 18 consecutive cycles at base+k, k=0..17. Capture byte k one cycle after its read: k<9 → weights[k], else biases[k-9]. After the last capture (19 cycles after LOAD entry) go to FLUSH.
- FLUSH: conv_flush=1 for exactly one cycle, then STREAM with pix_cnt=0, res_cnt=0.
- STREAM:
  - pix_ready = conv_idle & (pix_cnt<P).
  - pix_cnt increments on each conv_pixel_valid.
  - res_cnt increments on each conv_result_valid.
  - A pixel acceptance and a result in the same cycle both count.
  - When pix_cnt==P and res_cnt==E (including the same-cycle increment) → NEXT.
  - Extra results beyond E are not forwarded and are not counted.
- NEXT (1 cycle): ch+1, base+18. If ch+1==num_channels → DONE, else LOAD.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Weights and biases stay stable from the end of LOAD until the next LOAD starts.
- start while busy: ignored; no state change.
- out_valid is only ever high while out_ready=1, because the engine is gated by conv_accept.

Test Plan:
- D=5, stride=0, 1 channel, params 1..18, 25 ramp pixels → exactly 18 reads at addresses 0..17; weights=1..9, biases=10..18; one conv_flush; 9 out_valid pulses; then done, busy=0.
- D=7, stride=1, 3 channels → N=3, 9 results per channel (27 total); LOAD reads start at bases 0, 18, 36; 3 flushes; one done.
- out_ready held low for 20 cycles mid-channel → no out_valid while low, pix_ready stalls once conv is not idle; all 9 results arrive after release, none lost.
- start with D=2 → done and cfg_err together one cycle later; pmem_rd never asserted.
- num_channels=0 → done without cfg_err, no reads; start pulsed while busy → ignored, total done count is 1.
- Reset asserted during STREAM of channel 1 of 2 → all outputs 0 that cycle; a fresh start then reads from address 0.
